bitfusion_psum_accum: RTL

Output accumulator that sits directly downstream of the fusion-unit top. It consumes the registered 16-bit signed partial sum once per cycle and sums a programmed number of partial sums into a wide accumulator. It presents the finished dot-product result through a valid/ready handshake to the write-back logic. Each accumulation run is framed by a `start` pulse and a length value.

---
 rtl/bitfusion_psum_accum_if.sv | 27 ++
 rtl/bitfusion_psum_accum.sv | 98 +++++++++
 2 files changed

// File: rtl/bitfusion_psum_accum_if.sv
// Handshake bundle for the partial-sum accumulator.
// master: start/acc_len, psum stream, out_ready; slave: result side.
interface bitfusion_psum_accum_if #(
   parameter int PSUM_W = 16,
   parameter int ACC_W  = 32,
   parameter int LEN_W  = 8
);
   logic                     start;
   logic [LEN_W-1:0]         acc_len;
   logic signed [PSUM_W-1:0] psum;
   logic                     psum_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  acc_out;
   logic                     acc_valid;
   logic                     busy;
   logic                     overflow;

   modport master (
      output start, acc_len, psum, psum_valid, out_ready,
      input  acc_out, acc_valid, busy, overflow
   );

   modport slave (
      input  start, acc_len, psum, psum_valid, out_ready,
      output acc_out, acc_valid, busy, overflow
   );
endinterface

// File: rtl/bitfusion_psum_accum.sv
// Sums acc_len signed partial sums per run; result via valid/ready.
// Ports: clk, rst (async, active-high), bus (slave side of the if:
//   start/acc_len/psum/psum_valid/out_ready in, acc_out/acc_valid/
//   busy/overflow out). Define PSUM_ACC_SAT_EN for saturating sums
//   with a sticky overflow flag; otherwise sums wrap, overflow = 0.
module bitfusion_psum_accum #(
   parameter int PSUM_W = 16,
   parameter int ACC_W  = 32,
   parameter int LEN_W  = 8
) (
   input  logic clk,
   input  logic rst,
   bitfusion_psum_accum_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d, acc_add, psum_ext;
   logic [LEN_W-1:0]        cnt_q, cnt_d, len_q, len_d;
   logic                    ovf_q, ovf_d, ovf_hit;

   assign psum_ext = ACC_W'(bus.psum);

`ifdef PSUM_ACC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   logic [ACC_W:0] sum_wide;

   // One extra bit: top two bits differ exactly when the sum left range.
   always_comb begin
      sum_wide = {acc_q[ACC_W-1], acc_q} + {psum_ext[ACC_W-1], psum_ext};
      ovf_hit  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      if (!ovf_hit)
         acc_add = sum_wide[ACC_W-1:0];
      else if (sum_wide[ACC_W])
         acc_add = ACC_MIN;
      else
         acc_add = ACC_MAX;
   end
`else
   assign acc_add = acc_q + psum_ext;
   assign ovf_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               len_d   = bus.acc_len;
               state_d = (bus.acc_len == '0) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (bus.psum_valid) begin
               acc_d = acc_add;
               ovf_d = ovf_q | ovf_hit;
               cnt_d = cnt_q + LEN_W'(1);
               if (cnt_q == len_q - LEN_W'(1))
                  state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.acc_out   = acc_q;
   assign bus.acc_valid = (state_q == HOLD);
   assign bus.busy      = (state_q != IDLE);
   assign bus.overflow  = ovf_q;
endmodule
